// File: rtl/lcd_pkg.sv
// Shared constants and state types for the 1602 LCD driver.
// HD44780 command bytes plus top and byte-writer FSM encodings.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_FRAME
  } top_st_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_SETUP,
    B_EN,
    B_HOLD
  } byte_st_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = LCD_FUNC_SET;
      2'd1:    c = LCD_DISP_ON;
      2'd2:    c = LCD_ENTRY;
      default: c = LCD_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_wr.sv
// Single-byte writer: SETUP, EN-high, then HOLD wait on the LCD bus.
// A go in the last HOLD cycle chains the next byte with no gap.
module lcd_byte_wr
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC  = 4,
  parameter int CMD_WAIT_CYC = 50,
  parameter int CLR_WAIT_CYC = 2000
) (
  input  logic       lcd_clk,
  input  logic       rst,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int M1   = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
  localparam int MAXC = (M1 > CLR_WAIT_CYC) ? M1 : CLR_WAIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  byte_st_e        st, st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   wait_last;
  logic            lng;

  assign wait_last = lng ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  assign lcd_en    = (st == B_EN);

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      st       <= B_IDLE;
      cnt      <= '0;
      lng      <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      if (go) begin
        lcd_rs   <= rs;
        lcd_data <= data;
        lng      <= long_wait;
      end
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    done  = 1'b0;
    unique case (st)
      B_IDLE: if (go) st_n = B_SETUP;
      B_SETUP: begin
        st_n  = B_EN;
        cnt_n = '0;
      end
      B_EN: begin
        if (cnt == CW'(EN_HIGH_CYC - 1)) begin
          st_n  = B_HOLD;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      B_HOLD: begin
        if (cnt == wait_last) begin
          done = 1'b1;
          st_n = go ? B_SETUP : B_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: st_n = B_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd1602_drv.sv
// 1602 LCD driver top: power-up wait, init commands, two-line frames.
// Owns the row snapshot, the merged pending request and no_busy.
module lcd1602_drv
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 20000,
  parameter int EN_HIGH_CYC  = 4,
  parameter int CMD_WAIT_CYC = 50,
  parameter int CLR_WAIT_CYC = 2000
) (
  input  logic         lcd_clk,
  input  logic         rst,
  input  logic         start_show,
  input  logic [127:0] row_1,
  input  logic [127:0] row_2,
  output logic         no_busy,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data
);

  localparam int PW = $clog2(PWRUP_CYC + 1);

  top_st_e        st, st_n;
  logic [PW-1:0]  pw_cnt;
  logic [2:0]     init_idx;
  logic           line, hdr, fin, pend;
  logic [3:0]     ch;
  logic [255:0]   snap;
  logic [7:0]     bidx;

  logic           go, b_rs, b_long, b_done;
  logic [7:0]     b_data;
  logic           start_frame, adv_frame, adv_init, seq_end;

  // MSB index of the next data char inside {row_1,row_2}
  assign bidx    = {~line, ~ch, 3'b111};
  assign no_busy = (st == ST_IDLE) && !pend;
  assign lcd_rw  = 1'b0;

  always_comb begin
    st_n        = st;
    go          = 1'b0;
    b_rs        = 1'b0;
    b_data      = 8'h00;
    b_long      = 1'b0;
    start_frame = 1'b0;
    adv_frame   = 1'b0;
    adv_init    = 1'b0;
    seq_end     = 1'b0;
    unique case (st)
      ST_PWRUP: begin
        if (pw_cnt == PW'(PWRUP_CYC - 1)) begin
          st_n     = ST_INIT;
          adv_init = 1'b1;
        end
      end
      ST_INIT: begin
        if (b_done) begin
          if (init_idx != 3'd4) adv_init = 1'b1;
          else                  seq_end  = 1'b1;
        end
      end
      ST_IDLE: if (start_show) start_frame = 1'b1;
      ST_FRAME: begin
        if (b_done) begin
          if (!fin) adv_frame = 1'b1;
          else      seq_end   = 1'b1;
        end
      end
      default: st_n = ST_PWRUP;
    endcase
    if (seq_end) begin
      if (pend || start_show) start_frame = 1'b1;
      else                    st_n        = ST_IDLE;
    end
    if (start_frame) begin
      st_n   = ST_FRAME;
      go     = 1'b1;
      b_data = LCD_LINE1;
    end else if (adv_init) begin
      go     = 1'b1;
      b_data = init_cmd(init_idx[1:0]);
      b_long = (init_idx == 3'd3);
    end else if (adv_frame) begin
      go     = 1'b1;
      b_rs   = ~hdr;
      b_data = hdr ? LCD_LINE2 : snap[bidx -: 8];
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      st       <= ST_PWRUP;
      pw_cnt   <= '0;
      init_idx <= '0;
      line     <= 1'b0;
      hdr      <= 1'b0;
      ch       <= '0;
      fin      <= 1'b0;
      pend     <= 1'b0;
      snap     <= '0;
    end else begin
      st <= st_n;
      if (st == ST_PWRUP) pw_cnt <= pw_cnt + 1'b1;
      if (adv_init) init_idx <= init_idx + 1'b1;
      if (start_frame) begin
        snap <= {row_1, row_2};
        pend <= 1'b0;
        line <= 1'b0;
        hdr  <= 1'b0;
        ch   <= '0;
        fin  <= 1'b0;
      end else begin
        if (start_show && st != ST_IDLE) pend <= 1'b1;
        if (adv_frame) begin
          if (hdr) begin
            hdr <= 1'b0;
          end else begin
            ch <= ch + 1'b1;
            if (ch == 4'hF) begin
              if (line) begin
                fin <= 1'b1;
              end else begin
                line <= 1'b1;
                hdr  <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  lcd_byte_wr #(
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_byte (
    .lcd_clk  (lcd_clk),
    .rst      (rst),
    .go       (go),
    .rs       (b_rs),
    .data     (b_data),
    .long_wait(b_long),
    .done     (b_done),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

endmodule

// File: tb/tb_lcd1602_drv.sv
// Self-checking bench for lcd1602_drv: byte-queue reference model,
// bus monitor, directed scenarios and a randomized request phase.
module tb_lcd1602_drv;

  localparam int PWR  = 20;
  localparam int ENH  = 2;
  localparam int CMDW = 3;
  localparam int CLRW = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_show = 1'b0;
  logic [127:0] row_1 = '0;
  logic [127:0] row_2 = '0;
  logic         no_busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;

  lcd1602_drv #(
    .PWRUP_CYC   (PWR),
    .EN_HIGH_CYC (ENH),
    .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW)
  ) dut (
    .lcd_clk   (clk),
    .rst       (rst),
    .start_show(start_show),
    .row_1     (row_1),
    .row_2     (row_2),
    .no_busy   (no_busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of pending {rs,data} bytes and the offset
  // inside the byte at the queue head; frames are pushed as 34 bytes.
  logic [8:0] q[$];
  int   pw_left, off;
  bit   idle, pend, mvalid = 0;
  logic lrs;
  logic [7:0] ldat;

  function automatic int jt(input logic [8:0] j);
    return (j == 9'h001) ? 1 + ENH + CLRW : 1 + ENH + CMDW;
  endfunction

  task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
    q.push_back(9'h080);
    for (int i = 0; i < 16; i++) q.push_back({1'b1, a[127-8*i -: 8]});
    q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) q.push_back({1'b1, b[127-8*i -: 8]});
  endtask

  always @(posedge clk) begin
    bit last;
    if (rst) begin
      q.delete();
      pw_left = PWR;
      off = 0;
      idle = 0;
      pend = 0;
      lrs = 0;
      ldat = 8'h00;
      mvalid = 1;
    end else if (mvalid) begin
      if (pw_left > 0) begin
        if (start_show) pend = 1;
        pw_left--;
        if (pw_left == 0) begin
          q.push_back(9'h038);
          q.push_back(9'h00C);
          q.push_back(9'h006);
          q.push_back(9'h001);
          off = 0;
        end
      end else if (q.size() > 0) begin
        last = 0;
        off++;
        if (off == jt(q[0])) begin
          void'(q.pop_front());
          off = 0;
          last = (q.size() == 0);
        end
        if (last) begin
          if (pend || start_show) begin
            pend = 0;
            push_frame(row_1, row_2);
          end else begin
            idle = 1;
          end
        end else if (start_show) begin
          pend = 1;
        end
      end else if (start_show) begin
        idle = 0;
        push_frame(row_1, row_2);
      end
      if (q.size() > 0) begin
        lrs  = q[0][8];
        ldat = q[0][7:0];
      end
    end
  end

  always @(negedge clk) begin
    logic e_en;
    if (mvalid) begin
      e_en = (q.size() > 0) && off >= 1 && off <= ENH;
      chk("cycle {en,rs,rw,data,no_busy}",
          {lcd_en, lcd_rs, lcd_rw, lcd_data, no_busy},
          {e_en, lrs, 1'b0, ldat, idle});
    end
  end

  // Bus monitor: byte latched by the LCD on each lcd_en falling edge
  logic [8:0] cap[$];
  logic prev_en = 1'b0;
  always @(posedge clk) begin
    if (prev_en && !lcd_en) cap.push_back({lcd_rs, lcd_data});
    prev_en = lcd_en;
  end

  function automatic int frame_errs(input int base, input logic [127:0] a,
                                    input logic [127:0] b);
    int e = 0;
    if (cap.size() < base + 34) return 99;
    if (cap[base] !== 9'h080) e++;
    if (cap[base+17] !== 9'h0C0) e++;
    for (int i = 0; i < 16; i++) begin
      if (cap[base+1+i]  !== {1'b1, a[127-8*i -: 8]}) e++;
      if (cap[base+18+i] !== {1'b1, b[127-8*i -: 8]}) e++;
    end
    return e;
  endfunction

  task automatic pulse();
    start_show = 1'b1;
    @(negedge clk);
    start_show = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (!no_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!no_busy) chk("wait_idle timeout", 64'd0, 64'd1);
  endtask

  localparam logic [127:0] R_UP = "ABCDEFGHIJKLMNOP";
  localparam logic [127:0] R_LO = "abcdefghijklmnop";

  initial begin
    int n;
    logic [127:0] r1b, r2b, line1;
    // 1: power-up and init
    repeat (3) @(negedge clk);
    chk("reset no_busy/en", {no_busy, lcd_en, lcd_data}, 10'h000);
    rst = 1'b0;
    cap.delete();
    wait_idle(200, n);
    chk("pwrup+init latency", n, 51);
    chk("init byte count", cap.size(), 4);
    chk("init bytes", {cap[0], cap[1], cap[2], cap[3]},
        {9'h038, 9'h00C, 9'h006, 9'h001});
    // 2: one frame
    cap.delete();
    row_1 = R_UP;
    row_2 = R_LO;
    pulse();
    wait_idle(400, n);
    chk("frame busy length", n, 204);
    chk("frame bytes", frame_errs(0, "ABCDEFGHIJKLMNOP", "abcdefghijklmnop"), 0);
    // 3: row change mid-frame has no effect
    cap.delete();
    pulse();
    repeat (9) @(negedge clk);
    row_1 = {16{"Z"}};
    wait_idle(400, n);
    line1 = '0;
    for (int i = 0; i < 16; i++) line1[127-8*i -: 8] = cap[1+i][7:0];
    chk("snapshot line1", line1, 128'("ABCDEFGHIJKLMNOP"));
    // 4: three mid-frame pulses merge into one back-to-back frame
    cap.delete();
    row_1 = R_UP;
    row_2 = R_LO;
    r1b = {4{$urandom}};
    r2b = {$urandom, $urandom, $urandom, $urandom};
    pulse();
    n = 0;
    do begin
      n++;
      start_show = (n == 30 || n == 50 || n == 70);
      if (n == 20) begin
        row_1 = r1b;
        row_2 = r2b;
      end
      @(negedge clk);
    end while (!no_busy && n < 1000);
    start_show = 1'b0;
    chk("two frames busy length", n, 408);
    chk("two frames byte count", cap.size(), 68);
    chk("first frame old rows", frame_errs(0, R_UP, R_LO), 0);
    chk("second frame new rows", frame_errs(34, r1b, r2b), 0);
    // 5: request during init
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cap.delete();
    n = 0;
    do begin
      n++;
      start_show = (n == 30);
      @(negedge clk);
    end while (!no_busy && n < 1000);
    start_show = 1'b0;
    chk("init+frame latency", n, 255);
    chk("init+frame byte count", cap.size(), 38);
    chk("frame after init", frame_errs(4, r1b, r2b), 0);
    // 6: reset mid-frame
    pulse();
    n = 0;
    while (cap.size() < 12 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached byte 12", cap.size() >= 12, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset mid-frame outputs", {lcd_en, no_busy}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    cap.delete();
    n = 1;
    while (!no_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("re-init latency", n, 51);
    repeat (300) @(negedge clk);
    chk("no frame after reset", {no_busy, 32'(cap.size())}, {1'b1, 32'd4});
    // randomized requests and row changes
    for (int it = 0; it < 8; it++) begin
      row_1 = {$urandom, $urandom, $urandom, $urandom};
      row_2 = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 300; k++) begin
        start_show = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 19) == 0) row_1[31:0] = $urandom;
        @(negedge clk);
      end
      start_show = 1'b0;
      wait_idle(1000, n);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
